// File: rtl/serial_transceiver_fifo_if.sv
// Parallel-in / serial-out bus of serial_transceiver_fifo: push side, serial side and FIFO status.
// The parameters must match those of the transceiver that the bus is connected to.
interface serial_transceiver_fifo_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din;
  logic              sample;
  logic              startTx;
  logic [OUT_W-1:0]  dout;
  logic              doutValid;
  logic              txBusy;
  logic              txDone;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output din, sample, startTx,
    input  dout, doutValid, txBusy, txDone, full, empty, count, overflow
  );

  modport slave (
    input  din, sample, startTx,
    output dout, doutValid, txBusy, txDone, full, empty, count, overflow
  );
endinterface

// File: rtl/serial_transceiver_fifo.sv
// Word FIFO feeding a chunk serialiser. Each chunk is held on dout for DIV clocks, and every
// word is followed by a one-cycle DONE slot that carries the txDone pulse.
module serial_transceiver_fifo #(
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 4,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int DIV       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_transceiver_fifo_if.slave bus
);
  localparam int NCHUNK  = DATA_W / OUT_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int DIV_M1  = DIV - 1;
  localparam int NCH_M1  = NCHUNK - 1;
  localparam logic [DW-1:0] DIV_LAST = DIV_M1[DW-1:0];
  localparam logic [IW-1:0] IDX_LAST = NCH_M1[IW-1:0];
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // The registered full flag decides drops, so a same-cycle pop never rescues a push.
  assign push = bus.sample && !full_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d     = (count_d == FULL_CNT);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (bus.sample && full_q);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------- serialiser ----------------
  function automatic logic [OUT_W-1:0] lead_chunk(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_W-1 -: OUT_W];
    end
    return w[OUT_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_chunk(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w << OUT_W;
    end
    return w >> OUT_W;
  endfunction

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.startTx && !empty_q) begin
          // Chunk 0 goes straight to dout; the shift register keeps the rest.
          pop     = 1'b1;
          state_d = SHIFT;
          sh_d    = drop_chunk(head);
          dout_d  = lead_chunk(head);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          div_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          dout_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            dout_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            dout_d = lead_chunk(sh_q);
            sh_d   = drop_chunk(sh_q);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.doutValid = valid_q;
  assign bus.txBusy    = busy_q;
  assign bus.txDone    = done_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_transceiver_fifo.sv
// Bench for serial_transceiver_fifo: default instance (MSB first, DIV=2) plus an LSB-first DIV=1
// instance, with expected chunk streams derived from a word queue and plain shift arithmetic.
module tb_serial_transceiver_fifo;
  localparam int NCH = 8;
  localparam int A_DIV = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_transceiver_fifo_if #(.DATA_W(32), .OUT_W(4), .DEPTH(DEP)) ifa ();
  serial_transceiver_fifo_if #(.DATA_W(32), .OUT_W(4), .DEPTH(DEP)) ifb ();

  serial_transceiver_fifo #(.DATA_W(32), .OUT_W(4), .DEPTH(DEP), .MSB_FIRST(1), .DIV(A_DIV)) dut_a (
    .clk(clk), .reset(rst_n), .bus(ifa.slave)
  );
  serial_transceiver_fifo #(.DATA_W(32), .OUT_W(4), .DEPTH(DEP), .MSB_FIRST(0), .DIV(1)) dut_b (
    .clk(clk), .reset(rst_n), .bus(ifb.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model_q[$];
  bit ovf_exp = 1'b0;

  function automatic logic [3:0] exp_chunk(input logic [31:0] w, input int i, input bit msb);
    int sh;
    sh = msb ? 4 * (NCH - 1 - i) : 4 * i;
    return 4'((w >> sh) & 32'hF);
  endfunction

  task automatic push_a(input logic [31:0] w);
    ifa.din = w;
    ifa.sample = 1'b1;
    @(negedge clk);
    ifa.sample = 1'b0;
    if (model_q.size() < DEP) model_q.push_back(w);
    else ovf_exp = 1'b1;
  endtask

  // Starts on the negedge where chunk 0 of w is expected; ends on the DONE negedge.
  task automatic check_tx_a(input logic [31:0] w, input int drop_at);
    for (int i = 0; i < NCH; i++) begin
      for (int d = 0; d < A_DIV; d++) begin
        if (i == drop_at && d == 0) ifa.startTx = 1'b0;
        total_cnt++;
        if (ifa.dout !== exp_chunk(w, i, 1'b1))
          $display("FAIL tx_chunk word=%h chunk=%0d cyc=%0d dout=%h required=%h", w, i, d, ifa.dout, exp_chunk(w, i, 1'b1));
        else pass_cnt++;
        total_cnt++;
        if ({ifa.doutValid, ifa.txBusy, ifa.txDone} !== 3'b110)
          $display("FAIL tx_flags word=%h chunk=%0d valid/busy/done=%b required=110", w, i, {ifa.doutValid, ifa.txBusy, ifa.txDone});
        else pass_cnt++;
        @(negedge clk);
      end
    end
    total_cnt++;
    if ({ifa.doutValid, ifa.txBusy, ifa.txDone} !== 3'b001 || ifa.dout !== 4'h0)
      $display("FAIL tx_done word=%h valid/busy/done=%b dout=%h required=001 dout=0", w, {ifa.doutValid, ifa.txBusy, ifa.txDone}, ifa.dout);
    else pass_cnt++;
    $display("word %h transmitted, queue left %0d", w, model_q.size());
  endtask

  task automatic drain_all(input bit started);
    logic [31:0] w;
    if (!started) begin
      ifa.startTx = 1'b1;
      @(negedge clk);
    end
    while (model_q.size() > 0) begin
      w = model_q.pop_front();
      check_tx_a(w, -1);
      if (model_q.size() > 0) @(negedge clk);
    end
    ifa.startTx = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.empty} !== 4'b0001 || ifa.count !== 3'd0)
      $display("FAIL drain_idle valid/busy/done/empty=%b count=%0d required=0001 count=0", {ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.empty}, ifa.count);
    else pass_cnt++;
    total_cnt++;
    if (ifa.overflow !== ovf_exp)
      $display("FAIL drain_overflow overflow=%b required=%b", ifa.overflow, ovf_exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({ifa.dout, ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.overflow} !== 8'h00 ||
        {ifa.empty, ifa.full} !== 2'b10 || ifa.count !== 3'd0)
      $display("FAIL reset_state dout=%h v/b/d/o=%b empty/full=%b count=%0d", ifa.dout,
               {ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.overflow}, {ifa.empty, ifa.full}, ifa.count);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic_msb();
    push_a(32'hD6E5F198);
    total_cnt++;
    if (ifa.count !== 3'd1 || ifa.empty !== 1'b0)
      $display("FAIL basic_count count=%0d empty=%b required=1 0", ifa.count, ifa.empty);
    else pass_cnt++;
    ifa.startTx = 1'b1;
    @(negedge clk);
    ifa.startTx = 1'b0;
    check_tx_a(model_q.pop_front(), -1);
    @(negedge clk);
    total_cnt++;
    if (ifa.txDone !== 1'b0 || ifa.doutValid !== 1'b0 || ifa.empty !== 1'b1)
      $display("FAIL basic_idle txDone=%b valid=%b empty=%b required=0 0 1", ifa.txDone, ifa.doutValid, ifa.empty);
    else pass_cnt++;
  endtask

  task automatic test_lsb_first();
    logic [31:0] w;
    w = 32'hD6E5F198;
    ifb.din = w;
    ifb.sample = 1'b1;
    @(negedge clk);
    ifb.sample = 1'b0;
    ifb.startTx = 1'b1;
    @(negedge clk);
    ifb.startTx = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      total_cnt++;
      if (ifb.dout !== exp_chunk(w, i, 1'b0) || ifb.doutValid !== 1'b1 || ifb.txBusy !== 1'b1)
        $display("FAIL lsb_chunk chunk=%0d dout=%h valid=%b required=%h 1", i, ifb.dout, ifb.doutValid, exp_chunk(w, i, 1'b0));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (ifb.txDone !== 1'b1 || ifb.doutValid !== 1'b0 || ifb.txBusy !== 1'b0)
      $display("FAIL lsb_done txDone=%b valid=%b busy=%b required=1 0 0", ifb.txDone, ifb.doutValid, ifb.txBusy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ifb.txDone !== 1'b0 || ifb.empty !== 1'b1)
      $display("FAIL lsb_idle txDone=%b empty=%b required=0 1", ifb.txDone, ifb.empty);
    else pass_cnt++;
    $display("lsb-first word %h transmitted", w);
  endtask

  task automatic test_same_cycle_push();
    logic [31:0] w;
    w = $urandom;
    ifa.din = w;
    ifa.sample = 1'b1;
    ifa.startTx = 1'b1;
    @(negedge clk);
    ifa.sample = 1'b0;
    model_q.push_back(w);
    total_cnt++;
    if (ifa.doutValid !== 1'b0 || ifa.count !== 3'd1)
      $display("FAIL same_cycle_push valid=%b count=%0d required=0 1", ifa.doutValid, ifa.count);
    else pass_cnt++;
    @(negedge clk);
    drain_all(1'b1);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < DEP; k++) push_a($urandom);
    total_cnt++;
    if (ifa.full !== 1'b1 || ifa.count !== 3'd4 || ifa.overflow !== 1'b0)
      $display("FAIL fill full=%b count=%0d overflow=%b required=1 4 0", ifa.full, ifa.count, ifa.overflow);
    else pass_cnt++;
    push_a($urandom);
    total_cnt++;
    if (ifa.overflow !== 1'b1 || ifa.count !== 3'd4 || ifa.full !== 1'b1)
      $display("FAIL overflow overflow=%b count=%0d full=%b required=1 4 1", ifa.overflow, ifa.count, ifa.full);
    else pass_cnt++;
    drain_all(1'b0);
  endtask

  task automatic test_push_pop();
    logic [31:0] w;
    push_a($urandom);
    push_a($urandom);
    w = $urandom;
    ifa.din = w;
    ifa.sample = 1'b1;
    ifa.startTx = 1'b1;
    @(negedge clk);
    ifa.sample = 1'b0;
    model_q.push_back(w);
    total_cnt++;
    if (ifa.count !== 3'd2)
      $display("FAIL push_pop_count count=%0d required=2", ifa.count);
    else pass_cnt++;
    drain_all(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < DEP; k++) push_a($urandom);
      total_cnt++;
      if (ifa.full !== 1'b1 || ifa.count !== 3'd4)
        $display("FAIL wrap_fill round=%0d full=%b count=%0d required=1 4", r, ifa.full, ifa.count);
      else pass_cnt++;
      drain_all(1'b0);
    end
  endtask

  task automatic test_stop_mid();
    push_a($urandom);
    push_a($urandom);
    ifa.startTx = 1'b1;
    @(negedge clk);
    check_tx_a(model_q.pop_front(), 2);
    @(negedge clk);
    total_cnt++;
    if ({ifa.doutValid, ifa.txBusy, ifa.txDone} !== 3'b000 || ifa.count !== 3'd1)
      $display("FAIL stop_mid v/b/d=%b count=%0d required=000 count=1", {ifa.doutValid, ifa.txBusy, ifa.txDone}, ifa.count);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ifa.doutValid !== 1'b0 || ifa.count !== 3'd1)
      $display("FAIL stop_hold valid=%b count=%0d required=0 1", ifa.doutValid, ifa.count);
    else pass_cnt++;
    drain_all(1'b0);
  endtask

  task automatic test_reset_mid();
    push_a($urandom);
    push_a($urandom);
    ifa.startTx = 1'b1;
    @(negedge clk);
    ifa.startTx = 1'b0;
    repeat (3 * A_DIV) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({ifa.dout, ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.overflow} !== 8'h00 ||
        {ifa.empty, ifa.full} !== 2'b10 || ifa.count !== 3'd0)
      $display("FAIL reset_mid dout=%h v/b/d/o=%b empty/full=%b count=%0d", ifa.dout,
               {ifa.doutValid, ifa.txBusy, ifa.txDone, ifa.overflow}, {ifa.empty, ifa.full}, ifa.count);
    else pass_cnt++;
    model_q.delete();
    ovf_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ifa.startTx = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({ifa.doutValid, ifa.txBusy, ifa.txDone} !== 3'b000)
        $display("FAIL empty_start cyc=%0d v/b/d=%b required=000", c, {ifa.doutValid, ifa.txBusy, ifa.txDone});
      else pass_cnt++;
    end
    ifa.startTx = 1'b0;
    $display("reset mid-word and empty start done");
  endtask

  initial begin
    ifa.din = '0; ifa.sample = 1'b0; ifa.startTx = 1'b0;
    ifb.din = '0; ifb.sample = 1'b0; ifb.startTx = 1'b0;
    test_reset();
    test_basic_msb();
    test_lsb_first();
    test_same_cycle_push();
    test_overflow();
    test_push_pop();
    test_stop_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/serial_transceiver_fifo.md
Name: serial_transceiver_fifo

Overview:
Parametrised successor to the 4-bit serial transceiver. Buffers up to DEPTH parallel words in an internal FIFO. Serialises each word as DATA_W/OUT_W chunks of OUT_W bits, with selectable chunk order. A programmable clock-enable divider replaces the separate transmit clock, so the whole block runs in a single clock domain.

Parameters:
DATA_W, 32, parallel word width; must be a multiple of OUT_W
OUT_W, 4, serial chunk width; NCHUNK = DATA_W/OUT_W
DEPTH, 4, FIFO depth in words; power of two, ≥2
MSB_FIRST, 1, 1 = most-significant chunk first, 0 = least-significant chunk first
DIV, 2, clk cycles each chunk is held on dout; ≥1

Ports:
clk  input  1  single clock; rising edge
reset  input  1  asynchronous, active-low reset
din  input  DATA_W  word to enqueue
sample  input  1  push din into FIFO this cycle
startTx  input  1  level request to transmit
dout  output  OUT_W  current serial chunk
doutValid  output  1  dout holds a valid chunk
txBusy  output  1  word transmission in progress
txDone  output  1  one-cycle pulse after the last chunk of a word
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky; set on a push while full

Behaviour:
- Reset (reset=0, async) forces:
  - dout=0, doutValid=0, txBusy=0, txDone=0, overflow=0
  - empty=1, full=0, count=0
  - FIFO pointers cleared, FSM in IDLE, divider and chunk counters 0
- Reset asserted mid-word aborts the word; FIFO contents are discarded.
- FIFO push: sample=1 and not full → din written at tail, count+1.
  - sample=1 while full: din dropped, overflow=1 until reset.
  - If a pop happens in the same cycle, full refers to the pre-pop value, so the push is still dropped.
- FIFO pop: occurs on the IDLE/DONE→SHIFT transition; the head word is loaded into the shift register.
  - Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if startTx=1 and empty=0 at edge k → SHIFT at edge k. From edge k: dout = first chunk, doutValid=1, txBusy=1, divider=0, chunk index=0. Otherwise stay in IDLE.
  - SHIFT: each chunk is held exactly DIV cycles. When the divider reaches DIV-1, advance to the next chunk and reset the divider. After chunk NCHUNK-1 has been held DIV cycles → DONE.
  - DONE (1 cycle): txDone=1, txBusy=0, doutValid=0, dout=0. Next edge:
    - startTx=1 and FIFO non-empty → SHIFT (back-to-back; the one-cycle DONE gap is mandatory).
    - otherwise → IDLE.
- Chunk order:
  - MSB_FIRST=1: chunk i = din[DATA_W-1-i*OUT_W -: OUT_W]
  - MSB_FIRST=0: chunk i = din[i*OUT_W +: OUT_W]
- Word timing: NCHUNK*DIV cycles in SHIFT, then 1 cycle in DONE.
- startTx dropping during SHIFT does not abort the current word; it only suppresses the next word.
- startTx=1 with an empty FIFO is ignored (stay in IDLE, no txDone).
- A word pushed in the same cycle IDLE samples startTx is not visible until the next cycle (empty is the registered value).
- Outputs dout, doutValid, txBusy and txDone are registered.
- full, empty and count are registered from pointer state.

Test Plan:
1. Defaults; reset; push 32'hD6E5F198; startTx=1 for one cycle → dout sequence D,6,E,5,F,1,9,8, each chunk held 2 cycles. txBusy high 16 cycles, then txDone pulse of 1 cycle, then IDLE with empty=1.
2. MSB_FIRST=0, DIV=1, same word → dout 8,9,1,F,5,E,6,D on consecutive cycles, then txDone.
3. Push 4 words with startTx low → full=1, count=4. Push a 5th → overflow=1, count stays 4. Hold startTx=1 → four words transmitted in FIFO order, each separated by exactly one DONE cycle. Finally empty=1, overflow still 1.
4. Push and pop in the same cycle at count=2 → count stays 2; pointer wrap verified after 2*DEPTH pushes with data integrity checked.
5. Drop reset to 0 mid-word (chunk 3) → all outputs go to reset values immediately, without waiting for a clk edge. After release, startTx=1 with empty FIFO → no activity, txDone never pulses.
6. startTx deasserted during chunk 2 with 2 words queued → current word completes, txDone pulses, FSM returns to IDLE, count=1.
